conv33_sched: RTL

Sequencer that drives the 3x3 convolution datapath across a full feature map. It walks every valid output position of an `img_h` x `img_w` map (stride 1, no padding). For each position it reads the nine input pixels from a synchronous feature-map RAM, presents them as a packed window, and pulses `conv33_en`. It then captures the datapath's registered result and streams it out with a valid/ready handshake. It sits between the feature-map buffer and `conv33_calc`; weights and bias are supplied to the datapath elsewhere.

---
 rtl/conv33_sched_if.sv | 47 ++++
 rtl/conv33_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/conv33_sched_if.sv
// conv33_sched_if -- bundle of the sequencer's job-control, RAM-read,
// datapath and result-stream signals.
//
// Handshake semantics (result stream): out_valid, once raised, stays high
// with out_data/out_idx frozen until a cycle in which out_ready is also
// high; that cycle is the transfer. out_ready may toggle freely.
//
// modport master : the sequencer (conv33_sched) side
// modport slave  : the environment side (job controller, feature-map RAM,
//                  conv33_calc datapath, result consumer)
// dbg_state exposes the sequencer FSM state for observation.
interface conv33_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                    start;
  logic [DIM_WIDTH-1:0]    img_w;
  logic [DIM_WIDTH-1:0]    img_h;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    conv33_en;
  logic                    calc_valid;
  logic [OUT_WIDTH-1:0]    calc_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic [ADDR_WIDTH-1:0]   out_idx;
  logic [2:0]              dbg_state;

  modport master (
    input  start, img_w, img_h, rd_data, calc_valid, calc_result, out_ready,
    output busy, done, rd_en, rd_addr, win_data, conv33_en,
           out_valid, out_data, out_idx, dbg_state
  );

  modport slave (
    output start, img_w, img_h, rd_data, calc_valid, calc_result, out_ready,
    input  busy, done, rd_en, rd_addr, win_data, conv33_en,
           out_valid, out_data, out_idx, dbg_state
  );
endinterface

// File: rtl/conv33_sched.sv
// conv33_sched -- walks every valid 3x3 output position (stride 1, no
// padding) of an img_h x img_w feature map, reads the nine pixels from a
// synchronous RAM into a window register, fires the conv33_calc datapath,
// captures its result and streams it out with a valid/ready handshake.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset (aborts a job, no done)
//   bus        conv33_sched_if.master: start/img_w/img_h/busy/done job
//              control, rd_en/rd_addr/rd_data RAM port, win_data/conv33_en/
//              calc_valid/calc_result datapath, out_valid/out_ready/
//              out_data/out_idx result stream, dbg_state FSM state.
//
// Build option: define CONV33_REUSE_EN to slide the window left by one
// column when stepping along a row, so only the new right-hand column
// (3 reads) is loaded. The first window of every row is always a full
// 9-read load. Results are identical either way.
module conv33_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  conv33_sched_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0]  r_q, r_d, c_q, c_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;   // r*img_w, kept incrementally
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;     // outputs handed over so far
  logic [3:0]            cnt_q, cnt_d;     // reads issued in this LOAD
  logic [1:0]            i_q, i_d, j_q, j_d;
  logic                  full_q, full_d;   // 9-read load vs 3-read column
  logic                  cap_q, cap_d;     // rd_data is valid this cycle
  logic [3:0]            cap_k_q, cap_k_d; // window slot it belongs to
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [OUT_WIDTH-1:0]  data_q, data_d;

  logic                  degen, rd_en_c, last_c, last_r;
  logic [3:0]            n_reads;
  logic [ADDR_WIDTH-1:0] row_off, rd_addr_c;

  // Address of pixel (r+i, c+j) without a multiplier: base_q already
  // holds r*img_w and i only ranges over 0..2.
  always_comb begin
    degen   = (w_q < DIM_WIDTH'(3)) || (h_q < DIM_WIDTH'(3));
    n_reads = full_q ? 4'd9 : 4'd3;
    rd_en_c = (state_q == S_LOAD) && !degen && (cnt_q < n_reads);
    last_c  = (c_q == w_q - DIM_WIDTH'(3));
    last_r  = (r_q == h_q - DIM_WIDTH'(3));
    case (i_q)
      2'd0:    row_off = '0;
      2'd1:    row_off = ADDR_WIDTH'(w_q);
      default: row_off = ADDR_WIDTH'(w_q) << 1;
    endcase
    rd_addr_c = base_q + row_off + ADDR_WIDTH'(c_q) + ADDR_WIDTH'(j_q);
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    r_d     = r_q;
    c_d     = c_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    full_d  = full_q;
    data_d  = data_q;
    win_d   = win_q;
    cap_d   = rd_en_c;
    cap_k_d = 4'(i_q) * 4'd3 + 4'(j_q);

    // RAM data lands one cycle after its read strobe.
    if (cap_q) win_d[cap_k_q] = bus.rd_data;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          w_d     = bus.img_w;
          h_d     = bus.img_h;
          r_d     = '0;
          c_d     = '0;
          base_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          full_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Undersized maps are rejected here, on the latched dimensions,
        // before any read is issued.
        if (degen) begin
          state_d = S_DONE;
        end else if (rd_en_c) begin
          cnt_d = cnt_q + 4'd1;
          if (full_q && (j_q != 2'd2)) begin
            j_d = j_q + 2'd1;
          end else begin
            j_d = full_q ? 2'd0 : 2'd2;
            i_d = i_q + 2'd1;
          end
        end else begin
          // All reads issued; the final capture happens this cycle.
          state_d = S_FIRE;
        end
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.calc_valid) begin
          data_d  = bus.calc_result;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          idx_d  = idx_q + ADDR_WIDTH'(1);
          cnt_d  = '0;
          i_d    = '0;
          j_d    = '0;
          full_d = 1'b1;
          if (last_c) begin
            c_d = '0;
            if (last_r) begin
              state_d = S_DONE;
            end else begin
              r_d     = r_q + DIM_WIDTH'(1);
              base_d  = base_q + ADDR_WIDTH'(w_q);
              state_d = S_LOAD;
            end
          end else begin
            c_d     = c_q + DIM_WIDTH'(1);
            state_d = S_LOAD;
`ifdef CONV33_REUSE_EN
            full_d = 1'b0;
            j_d    = 2'd2;
            for (int i = 0; i < 3; i++) begin
              win_d[i*3]   = win_q[i*3+1];
              win_d[i*3+1] = win_q[i*3+2];
            end
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      full_q  <= 1'b0;
      cap_q   <= 1'b0;
      cap_k_q <= '0;
      data_q  <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      c_q     <= c_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      full_q  <= full_d;
      cap_q   <= cap_d;
      cap_k_q <= cap_k_d;
      data_q  <= data_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    bus.win_data = '0;
    for (int k = 0; k < 9; k++) bus.win_data[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
  end

  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_en_c ? rd_addr_c : '0;
  assign bus.conv33_en = (state_q == S_FIRE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.dbg_state = state_q;
endmodule
